// File: rtl/ps2_scan_rx.sv
// ps2_scan_rx: PS/2 device-to-host deframer feeding a show-ahead scan-code FIFO.
// Define PS2_BREAK_FILTER_EN to drop F0 break prefixes and the byte that follows each one.
module ps2_scan_rx #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       rd_en,
    output logic [7:0] scan_code,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

    logic [2:0]    ps2c_q;
    logic [1:0]    ps2d_q;
    logic [3:0]    bit_q, bit_d;
    logic [9:0]    sh_q, sh_d;
    logic [TW-1:0] to_q, to_d;
    logic [7:0]    byte_q;
    logic          good_q, good_d, err_q, err_d;
    logic          fall, last, timeout, frame_ok, push, pop, full, wr;
    logic [AW:0]   wp_q, rp_q, cnt;
    logic          ovf_q;
    logic [7:0]    mem_q [FIFO_DEPTH];

    // sh_q fills from the top, so at the stop-bit edge [0]=start, [8:1]=data, [9]=parity
    always_comb begin
        fall     = ps2c_q[2:1] == 2'b10;
        last     = bit_q == 4'd10;
        timeout  = (bit_q != 4'd0) && !fall && (to_q == TO_LAST);
        bit_d    = timeout ? 4'd0 : fall ? (last ? 4'd0 : bit_q + 4'd1) : bit_q;
        sh_d     = fall ? {ps2d_q[1], sh_q[9:1]} : sh_q;
        to_d     = (fall || bit_q == 4'd0) ? '0 : to_q + 1'b1;
        frame_ok = ~sh_q[0] & ps2d_q[1] & (^sh_q[9:1]);
        good_d   = fall & last & frame_ok;
        err_d    = (fall & last & ~frame_ok) | timeout;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ps2c_q <= '0;
            ps2d_q <= '0;
            bit_q  <= '0;
            sh_q   <= '0;
            to_q   <= '0;
            byte_q <= '0;
            good_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ps2c_q <= {ps2c_q[1:0], ps2_clk};
            ps2d_q <= {ps2d_q[0], ps2_data};
            bit_q  <= bit_d;
            sh_q   <= sh_d;
            to_q   <= to_d;
            byte_q <= (fall && last) ? sh_q[8:1] : byte_q;
            good_q <= good_d;
            err_q  <= err_d;
        end
    end

`ifdef PS2_BREAK_FILTER_EN
    typedef enum logic {IDLE, BREAK} state_t;
    state_t st_q, st_d;

    always_comb begin
        st_d = st_q;
        push = 1'b0;
        if (good_q) begin
            if (st_q == BREAK) st_d = IDLE;
            else if (byte_q == 8'hF0) st_d = BREAK;
            else push = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) st_q <= IDLE;
        else st_q <= st_d;
    end
`else
    assign push = good_q;
`endif

    assign cnt       = wp_q - rp_q;
    assign full      = cnt == FULL_CNT;
    assign ready     = wp_q != rp_q;
    assign pop       = rd_en & ready;
    assign wr        = push & (~full | pop);
    assign scan_code = ready ? mem_q[rp_q[AW-1:0]] : 8'h00;
    assign overflow  = ovf_q;
    assign frame_err = err_q;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            wp_q  <= wr ? wp_q + 1'b1 : wp_q;
            rp_q  <= pop ? rp_q + 1'b1 : rp_q;
            ovf_q <= ovf_q | (push & full & ~pop);
        end
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wp_q[AW-1:0]] <= byte_q;
    end
endmodule
